// File: rtl/uart_rx_decrypt.sv
// rtl/uart_rx_decrypt.sv - UART receiver (8N1, or 8E1 with PARITY_CHECK_EN) that adds a key to each received byte
module uart_rx_decrypt #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic [2:0] baud_sel,
    input  logic [7:0] encryption_key,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    localparam int DIV_W = $clog2(CLK_HZ / (16 * 300) + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_sample;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
`ifdef PARITY_CHECK_EN
    logic             r_par_err;
`endif

    logic [DIV_W-1:0] w_div_sel;
    logic             w_rx;
    logic             w_fall;
    logic             w_tick;
    logic             w_sample;

    always_comb begin
        w_div_sel = DIV_W'(CLK_HZ / (16 * 300));
        case (baud_sel)
            3'd0: w_div_sel = DIV_W'(CLK_HZ / (16 * 300));
            3'd1: w_div_sel = DIV_W'(CLK_HZ / (16 * 1200));
            3'd2: w_div_sel = DIV_W'(CLK_HZ / (16 * 4800));
            3'd3: w_div_sel = DIV_W'(CLK_HZ / (16 * 9600));
            3'd4: w_div_sel = DIV_W'(CLK_HZ / (16 * 19200));
            3'd5: w_div_sel = DIV_W'(CLK_HZ / (16 * 38400));
            3'd6: w_div_sel = DIV_W'(CLK_HZ / (16 * 57600));
            3'd7: w_div_sel = DIV_W'(CLK_HZ / (16 * 115200));
            default: w_div_sel = DIV_W'(CLK_HZ / (16 * 300));
        endcase
    end

    assign w_rx     = r_sync[1];
    assign w_fall   = r_rx_prev & ~w_rx;
    assign w_tick   = (r_div_cnt == r_div - DIV_W'(1));
    // The sample counter wraps every 16 ticks, so hitting 7->8 lands mid-bit in every state
    assign w_sample = w_tick && (r_sample == 4'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_sample  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef PARITY_CHECK_EN
            r_par_err <= 1'b0;
`endif
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
            Rx_PERROR <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], RxD};
            r_rx_prev <= w_rx;
            Rx_VALID  <= 1'b0;

            if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_sample  <= r_sample + 4'd1;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end

            if (r_state != S_IDLE && !Rx_EN) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Rx_EN && w_fall) begin
                            r_state   <= S_START;
                            r_div     <= w_div_sel;
                            r_div_cnt <= '0;
                            r_sample  <= '0;
                        end
                    end
                    S_START: begin
                        r_bit_cnt <= '0;
                        if (w_sample)
                            r_state <= w_rx ? S_IDLE : S_DATA;
                    end
                    S_DATA: begin
                        if (w_sample) begin
                            r_shift   <= {w_rx, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
`ifdef PARITY_CHECK_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef PARITY_CHECK_EN
                    S_PARITY: begin
                        if (w_sample) begin
                            r_par_err <= (w_rx != ^r_shift);
                            r_state   <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_sample) begin
                            Rx_DATA   <= r_shift + encryption_key;
                            Rx_FERROR <= ~w_rx;
`ifdef PARITY_CHECK_EN
                            Rx_PERROR <= r_par_err;
`else
                            Rx_PERROR <= 1'b0;
`endif
                            Rx_VALID  <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_decrypt.sv
// tb/tb_uart_rx_decrypt.sv - directed self-checking bench for uart_rx_decrypt at 50 MHz
module tb_uart_rx_decrypt;

    localparam int BIT  = 432;
    localparam int BIT6 = 864;

    logic       clk;
    logic       reset;
    logic       Rx_EN;
    logic       RxD;
    logic [2:0] baud_sel;
    logic [7:0] encryption_key;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;

    int n_chk  = 0;
    int n_pass = 0;
    int vcnt   = 0;
    int exp_v  = 0;
    int wide   = 0;
    logic       prev_v = 1'b0;
    logic [7:0] last_d = 8'h00;
    logic [7:0] prev_d = 8'h00;

    uart_rx_decrypt #(.CLK_HZ(50_000_000)) dut (
        .clk            (clk),
        .reset          (reset),
        .Rx_EN          (Rx_EN),
        .RxD            (RxD),
        .baud_sel       (baud_sel),
        .encryption_key (encryption_key),
        .Rx_DATA        (Rx_DATA),
        .Rx_VALID       (Rx_VALID),
        .Rx_FERROR      (Rx_FERROR),
        .Rx_PERROR      (Rx_PERROR)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (Rx_VALID) begin
            vcnt   = vcnt + 1;
            prev_d = last_d;
            last_d = Rx_DATA;
            if (prev_v) wide = wide + 1;
        end
        prev_v = Rx_VALID;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic line(input logic v, input int n);
        RxD = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic flip_par,
                              input int bclk, input logic chg);
        line(1'b0, bclk);
        if (chg) baud_sel = 3'd6;
        for (int i = 0; i < 8; i++) line(b[i], bclk);
`ifdef PARITY_CHECK_EN
        line((^b) ^ flip_par, bclk);
`endif
        line(stop, bclk);
        RxD = 1'b1;
        @(negedge clk);
    endtask

    task automatic partial_to_bit4(input logic [7:0] b);
        line(1'b0, BIT);
        for (int i = 0; i < 4; i++) line(b[i], BIT);
        line(b[4], BIT / 2);
    endtask

    initial begin
        reset = 1'b0; Rx_EN = 1'b1; RxD = 1'b1; baud_sel = 3'd7; encryption_key = 8'h10;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  Rx_DATA,   8'h00);
        chk("rst_valid", Rx_VALID,  1'b0);
        chk("rst_ferr",  Rx_FERROR, 1'b0);
        chk("rst_perr",  Rx_PERROR, 1'b0);
        reset = 1'b1;
        line(1'b1, 20);

        send_frame(8'h95, 1'b1, 1'b0, BIT, 1'b0);
        exp_v++;
        chk("f95_vcnt", vcnt,      exp_v);
        chk("f95_data", Rx_DATA,   8'hA5);
        chk("f95_ferr", Rx_FERROR, 1'b0);
        chk("f95_perr", Rx_PERROR, 1'b0);

        send_frame(8'hF8, 1'b1, 1'b0, BIT, 1'b0);
        exp_v++;
        chk("wrap_vcnt", vcnt,    exp_v);
        chk("wrap_data", Rx_DATA, 8'h08);

        line(1'b0, 4 * 27);
        line(1'b1, 2 * BIT);
        @(negedge clk);
        chk("glitch_vcnt", vcnt,      exp_v);
        chk("glitch_data", Rx_DATA,   8'h08);
        chk("glitch_ferr", Rx_FERROR, 1'b0);

        send_frame(8'h3C, 1'b0, 1'b0, BIT, 1'b0);
        exp_v++;
        line(1'b1, BIT);
        chk("ferr_vcnt", vcnt,      exp_v);
        chk("ferr_data", Rx_DATA,   8'h4C);
        chk("ferr_flag", Rx_FERROR, 1'b1);

        encryption_key = 8'h20;
        send_frame(8'h00, 1'b1, 1'b0, BIT, 1'b0);
        exp_v++;
        chk("clr_vcnt", vcnt,      exp_v);
        chk("clr_data", Rx_DATA,   8'h20);
        chk("clr_ferr", Rx_FERROR, 1'b0);

`ifdef PARITY_CHECK_EN
        encryption_key = 8'h10;
        send_frame(8'h01, 1'b1, 1'b1, BIT, 1'b0);
        exp_v++;
        chk("par_vcnt", vcnt,      exp_v);
        chk("par_data", Rx_DATA,   8'h11);
        chk("par_perr", Rx_PERROR, 1'b1);
        send_frame(8'h01, 1'b1, 1'b0, BIT, 1'b0);
        exp_v++;
        chk("par_ok",   Rx_PERROR, 1'b0);
`endif

        encryption_key = 8'h00;
        partial_to_bit4(8'hFF);
        RxD = 1'b1; Rx_EN = 1'b0;
        line(1'b1, 4);
        Rx_EN = 1'b1;
        line(1'b1, 3 * BIT);
        chk("en_abort_vcnt", vcnt,    exp_v);
        chk("en_abort_data", Rx_DATA, 8'h20);
        send_frame(8'h55, 1'b1, 1'b0, BIT, 1'b0);
        exp_v++;
        chk("en_next_vcnt", vcnt,    exp_v);
        chk("en_next_data", Rx_DATA, 8'h55);

        encryption_key = 8'h33;
        partial_to_bit4(8'h0F);
        RxD = 1'b1; reset = 1'b0;
        #3;
        chk("rst_mid_data", Rx_DATA, 8'h00);
        line(1'b1, 4);
        reset = 1'b1;
        line(1'b1, 3 * BIT);
        chk("rst_abort_vcnt", vcnt, exp_v);
        encryption_key = 8'h00;
        send_frame(8'h55, 1'b1, 1'b0, BIT, 1'b0);
        exp_v++;
        chk("rst_next_vcnt", vcnt,    exp_v);
        chk("rst_next_data", Rx_DATA, 8'h55);

        send_frame(8'h12, 1'b1, 1'b0, BIT, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, BIT, 1'b0);
        exp_v += 2;
        chk("b2b_vcnt",  vcnt,   exp_v);
        chk("b2b_first", prev_d, 8'h12);
        chk("b2b_last",  last_d, 8'h34);

        encryption_key = 8'h10;
        send_frame(8'h5A, 1'b1, 1'b0, BIT, 1'b1);
        exp_v++;
        chk("selchg_vcnt", vcnt,    exp_v);
        chk("selchg_data", Rx_DATA, 8'h6A);

        send_frame(8'h81, 1'b1, 1'b0, BIT6, 1'b0);
        exp_v++;
        chk("b57k_vcnt", vcnt,    exp_v);
        chk("b57k_data", Rx_DATA, 8'h91);

        chk("valid_width", wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
